// File: rtl/ram_bank_if.sv
// rtl/ram_bank_if.sv - access, clear and status bundle for ram_bank
interface ram_bank_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
);
  logic                  cen;
  logic                  wen;
  logic [DATA_W/8-1:0]   s_be;
  logic [ADDR_W-1:0]     s_addr;
  logic [DATA_W-1:0]     s_din;
  logic [DATA_W-1:0]     s_dout;
  logic                  s_valid;
  logic                  clr;
  logic                  busy;

  // Controller side: issues accesses and clear requests, observes results
  modport master (
    output cen, wen, s_be, s_addr, s_din, clr,
    input  s_dout, s_valid, busy
  );

  // RAM side: accepts accesses and clear requests, returns results
  modport slave (
    input  cen, wen, s_be, s_addr, s_din, clr,
    output s_dout, s_valid, busy
  );
endinterface

// File: rtl/ram_bank.sv
// rtl/ram_bank.sv - parametrised single-port RAM bank with byte enables and clear engine
module ram_bank #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 8,
  parameter int OUT_REG = 0
) (
  input  logic      clk,
  input  logic      reset_n,
  ram_bank_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_addr;
  logic              idle;
  logic              clr_last;
  logic              rd_en;
  logic              wr_en;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_raw;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  // A clear request in IDLE takes priority over any access in the same cycle;
  // while clearing, every access and clear request is ignored.
  assign idle     = (state == ST_IDLE);
  assign rd_en    = idle && !bus.clr && bus.cen && !bus.wen;
  assign wr_en    = idle && !bus.clr && bus.cen &&  bus.wen;
  // Terminal compare on the last word ends the sweep after exactly DEPTH writes
  assign clr_last = &clr_addr;

  // Clear sequencer: sweep every word once, then accept accesses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_last) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (bus.clr) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
          end
        end
        default: begin
          state    <= ST_CLEAR;
          clr_addr <= '0;
        end
      endcase
    end
  end

  // Storage array: clear writes, byte-masked writes and the synchronous read
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.s_be[i]) begin
          mem[bus.s_addr][8*i +: 8] <= bus.s_din[8*i +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_raw <= mem[bus.s_addr];
    end
  end

  // Read-result marker; resetting it discards any read in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
    end
  end

  // The raw array output is only exposed while it holds a fresh read result,
  // so every other cycle presents zero instead of stale or undefined data.
  assign rd_data = rd_valid ? rd_raw : '0;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] q_data;
      logic              q_valid;

      // Optional output stage; it keeps draining during a clear so a read
      // accepted just before clr still delivers its result.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          q_data  <= '0;
          q_valid <= 1'b0;
        end else begin
          q_data  <= rd_data;
          q_valid <= rd_valid;
        end
      end

      assign bus.s_dout  = q_data;
      assign bus.s_valid = q_valid;
    end else begin : g_direct
      assign bus.s_dout  = rd_data;
      assign bus.s_valid = rd_valid;
    end
  endgenerate

  assign bus.busy = (state == ST_CLEAR);

endmodule
